// File: rtl/record_core.sv
// record_core: audio capture engine. Decimates codec samples into a small FIFO,
// drains them to SDRAM from rec_select+1, then writes the word count at rec_select.
//
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   rec_start, rec_select           begin recording, header address (latched)
//   rec_pause, rec_stop             drop samples while high, end recording
//   rec_done                        pulse when the header write is acknowledged
//   rec_write, rec_addr,
//   rec_writedata                   SDRAM write request, address and data
//   rec_sdram_finished              SDRAM write acknowledge
//   rec_audio_valid, rec_audio_data,
//   rec_audio_ready                 codec sample handshake
module record_core #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          DECIM      = 2,
    parameter logic [22:0] MAX_WORDS  = 23'h7FFFF0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        rec_start,
    input  logic [22:0] rec_select,
    input  logic        rec_pause,
    input  logic        rec_stop,
    output logic        rec_done,
    output logic        rec_write,
    output logic [22:0] rec_addr,
    output logic [31:0] rec_writedata,
    input  logic        rec_sdram_finished,
    input  logic        rec_audio_valid,
    input  logic [31:0] rec_audio_data,
    output logic        rec_audio_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECORD,
        S_FLUSH,
        S_WRITE_LEN
    } state_t;

    state_t        state;
    logic [22:0]   sel;
    logic [22:0]   wptr;
    logic [22:0]   count;
    logic [PW-1:0] phase;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;

    logic          draining;
    logic          fifo_empty;
    logic          fifo_full;
    logic          accept;
    logic          push;
    logic          pop;
    logic [OW-1:0] occ_next;
    logic [22:0]   count_next;
    logic [PW-1:0] phase_inc;

    assign draining   = (state == S_RECORD) || (state == S_FLUSH);
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == DEPTH_C);

    assign rec_audio_ready = (state == S_RECORD) && !fifo_full;
    assign accept     = rec_audio_valid && rec_audio_ready;
    // Only the first sample of each decimation group is kept.
    assign push       = accept && !rec_pause && (phase == '0);
    assign pop        = draining && !fifo_empty && rec_sdram_finished;
    assign occ_next   = occ + OW'(push) - OW'(pop);
    assign count_next = count + 23'(push);
    assign phase_inc  = (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);

    assign rec_done   = (state == S_WRITE_LEN) && rec_sdram_finished;

    always_comb begin
        rec_write     = 1'b0;
        rec_addr      = '0;
        rec_writedata = '0;
        unique case (1'b1)
            (state == S_WRITE_LEN): begin
                rec_write     = 1'b1;
                rec_addr      = sel;
                rec_writedata = {9'b0, count};
            end
            (draining && !fifo_empty): begin
                rec_write     = 1'b1;
                rec_addr      = wptr;
                rec_writedata = mem[rd_ptr];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= rec_audio_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            sel    <= '0;
            wptr   <= '0;
            count  <= '0;
            phase  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rec_start) begin
                        sel    <= rec_select;
                        wptr   <= rec_select + 23'd1;
                        count  <= '0;
                        phase  <= '0;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        occ    <= '0;
                        state  <= S_RECORD;
                    end
                end
                S_RECORD, S_FLUSH: begin
                    occ <= occ_next;
                    if (push) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        count  <= count_next;
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        wptr   <= wptr + 23'd1;
                    end
                    if (accept) begin
                        phase <= rec_pause ? '0 : phase_inc;
                    end
                    // Skip FLUSH when nothing is left to drain so the
                    // header goes out the very next cycle.
                    if (state == S_RECORD) begin
                        if (rec_stop || (push && count_next == MAX_WORDS)) begin
                            state <= (occ_next == '0) ? S_WRITE_LEN : S_FLUSH;
                        end
                    end else if (occ_next == '0) begin
                        state <= S_WRITE_LEN;
                    end
                end
                S_WRITE_LEN: begin
                    if (rec_sdram_finished) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_record_core.sv
// tb_record_core: scoreboard bench for record_core.
// Expected SDRAM writes are queued as samples are driven and matched on commit.
module tb_record_core;

    localparam int DEPTH = 4;
    localparam int DEC   = 2;

    typedef struct {
        logic [22:0] addr;
        logic [31:0] data;
        logic        hdr;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        rec_start = 1'b0;
    logic [22:0] rec_select = '0;
    logic        rec_pause = 1'b0;
    logic        rec_stop = 1'b0;
    logic        fin = 1'b0;
    logic        rec_audio_valid = 1'b0;
    logic [31:0] rec_audio_data = '0;

    logic        d_done, d_write, d_ready;
    logic [22:0] d_addr;
    logic [31:0] d_data;
    logic        m_done, m_write, m_ready;
    logic [22:0] m_addr;
    logic [31:0] m_data;

    logic        w_done, w_write, w_ready;
    logic [22:0] w_addr;
    logic [31:0] w_data;

    bit          use_max = 0;
    bit          hold = 0;
    int          ack_lat = 1;
    int          wait_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;

    exp_t        sb[$];
    logic [22:0] sel_m = '0;
    logic [22:0] cnt_m = '0;
    logic [22:0] max_m = 23'h7FFFF0;
    int          ph_m = 0;

    record_core #(.FIFO_DEPTH(DEPTH), .DECIM(DEC)) u_dut (
        .i_clk(clk), .i_rst(i_rst),
        .rec_start(rec_start), .rec_select(rec_select),
        .rec_pause(rec_pause), .rec_stop(rec_stop),
        .rec_done(d_done), .rec_write(d_write),
        .rec_addr(d_addr), .rec_writedata(d_data),
        .rec_sdram_finished(fin),
        .rec_audio_valid(rec_audio_valid), .rec_audio_data(rec_audio_data),
        .rec_audio_ready(d_ready)
    );

    record_core #(.FIFO_DEPTH(DEPTH), .DECIM(DEC), .MAX_WORDS(23'd3)) u_max (
        .i_clk(clk), .i_rst(i_rst),
        .rec_start(rec_start), .rec_select(rec_select),
        .rec_pause(rec_pause), .rec_stop(rec_stop),
        .rec_done(m_done), .rec_write(m_write),
        .rec_addr(m_addr), .rec_writedata(m_data),
        .rec_sdram_finished(fin),
        .rec_audio_valid(rec_audio_valid), .rec_audio_data(rec_audio_data),
        .rec_audio_ready(m_ready)
    );

    assign w_done  = use_max ? m_done  : d_done;
    assign w_write = use_max ? m_write : d_write;
    assign w_ready = use_max ? m_ready : d_ready;
    assign w_addr  = use_max ? m_addr  : d_addr;
    assign w_data  = use_max ? m_data  : d_data;

    always #5 clk = ~clk;

    // SDRAM model: acknowledge each presented word after ack_lat idle cycles.
    always @(posedge clk) begin
        #1;
        if (w_write && !hold && !i_rst) begin
            if (wait_cnt >= ack_lat) begin
                fin = 1'b1;
                wait_cnt = 0;
            end else begin
                fin = 1'b0;
                wait_cnt++;
            end
        end else begin
            fin = 1'b0;
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!i_rst) begin
            if (w_write && fin) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got addr=%h data=%h", w_addr, w_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (w_addr !== e.addr || w_data !== e.data || w_done !== e.hdr) begin
                        errors++;
                        $display("FAIL sdram_write got addr=%h data=%h done=%b expected addr=%h data=%h done=%b",
                                 w_addr, w_data, w_done, e.addr, e.data, e.hdr);
                    end
                end
            end else if (w_done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done got done=%b expected 0", w_done);
            end
            if (w_done === 1'b1) done_cnt++;
        end
    end

    function automatic void model_accept(input logic [31:0] d, input logic p);
        if (p) begin
            ph_m = 0;
        end else begin
            if (ph_m == 0) begin
                sb.push_back('{sel_m + 23'd1 + cnt_m, d, 1'b0});
                cnt_m++;
                if (cnt_m == max_m) sb.push_back('{sel_m, {9'b0, cnt_m}, 1'b1});
            end
            ph_m = (ph_m + 1) % DEC;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        rec_start = 1'b0;
        rec_stop = 1'b0;
        rec_pause = 1'b0;
        rec_audio_valid = 1'b0;
        hold = 0;
        repeat (2) @(negedge clk);
        sb.delete();
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_rec(input logic [22:0] s);
        rec_select = s;
        rec_start = 1'b1;
        sel_m = s;
        cnt_m = '0;
        ph_m = 0;
        @(negedge clk);
        rec_start = 1'b0;
        checks++;
        if (w_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready got %b expected 1", w_ready);
        end
    endtask

    task automatic stop_rec();
        rec_stop = 1'b1;
        sb.push_back('{sel_m, {9'b0, cnt_m}, 1'b1});
        @(negedge clk);
        rec_stop = 1'b0;
        checks++;
        if (w_ready !== 1'b0) begin
            errors++;
            $display("FAIL stop_ready got %b expected 0", w_ready);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic p);
        int n = 0;
        rec_audio_valid = 1'b1;
        rec_audio_data = d;
        rec_pause = p;
        while (w_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout data=%h got ready=0 expected 1", d);
        end else begin
            model_accept(d, p);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL %s_done got %0d pulses expected 1", nm, done_cnt - d0);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got %0d writes outstanding expected 0", nm, sb.size());
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        checks++;
        if (w_done !== 1'b0 || w_write !== 1'b0 || w_ready !== 1'b0 ||
            w_addr !== 23'd0 || w_data !== 32'd0) begin
            errors++;
            $display("FAIL %s got done=%b write=%b ready=%b addr=%h data=%h expected all 0",
                     nm, w_done, w_write, w_ready, w_addr, w_data);
        end
    endtask

    task automatic test_reset();
        use_max = 0;
        do_reset();
        check_idle_outputs("reset_main");
        use_max = 1;
        check_idle_outputs("reset_max");
        use_max = 0;
    endtask

    task automatic test_basic();
        int d0;
        do_reset();
        ack_lat = 1;
        d0 = done_cnt;
        start_rec(23'h100);
        for (int i = 0; i < 8; i++) send(32'hA0 + i, 1'b0);
        rec_audio_valid = 1'b0;
        stop_rec();
        wait_done(d0, "basic");
    endtask

    task automatic test_backpressure();
        int d0;
        int acc = 0;
        logic [31:0] d = 32'h200;
        do_reset();
        ack_lat = 0;
        hold = 1;
        d0 = done_cnt;
        start_rec(23'h040);
        rec_audio_valid = 1'b1;
        rec_audio_data = d;
        repeat (20) begin
            if (w_ready === 1'b1) begin
                model_accept(d, 1'b0);
                acc++;
                d++;
            end
            @(negedge clk);
            rec_audio_data = d;
        end
        checks++;
        if (acc != 2 * DEPTH - 1 || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill got accepted=%0d ready=%b expected accepted=%0d ready=0",
                     acc, w_ready, 2 * DEPTH - 1);
        end
        checks++;
        if (w_write !== 1'b1 || w_addr !== 23'h041 || w_data !== 32'h200) begin
            errors++;
            $display("FAIL bp_hold got write=%b addr=%h data=%h expected 1 041 00000200",
                     w_write, w_addr, w_data);
        end
        rec_audio_valid = 1'b0;
        hold = 0;
        stop_rec();
        wait_done(d0, "bp");
    endtask

    task automatic test_pause();
        int d0;
        do_reset();
        ack_lat = 0;
        d0 = done_cnt;
        start_rec(23'h7FFFFE);
        for (int i = 1; i <= 10; i++) send(32'(i), (i >= 3 && i <= 6));
        rec_audio_valid = 1'b0;
        rec_pause = 1'b0;
        checks++;
        if (cnt_m != 23'd3) begin
            errors++;
            $display("FAIL pause_model got %0d kept expected 3", cnt_m);
        end
        stop_rec();
        wait_done(d0, "pause");
    endtask

    task automatic test_immediate_stop();
        int d0;
        do_reset();
        ack_lat = 1;
        d0 = done_cnt;
        start_rec(23'h3AB);
        stop_rec();
        checks++;
        if (w_write !== 1'b1 || w_addr !== 23'h3AB || w_data !== 32'd0) begin
            errors++;
            $display("FAIL imm_header got write=%b addr=%h data=%h expected 1 3ab 00000000",
                     w_write, w_addr, w_data);
        end
        wait_done(d0, "imm");
    endtask

    task automatic test_max();
        int d0;
        int n = 0;
        bit hit = 0;
        logic [31:0] d = 32'h500;
        do_reset();
        use_max = 1;
        max_m = 23'd3;
        ack_lat = 1;
        d0 = done_cnt;
        start_rec(23'h010);
        rec_audio_valid = 1'b1;
        rec_audio_data = d;
        while (done_cnt == d0 && n < 200) begin
            if (w_ready === 1'b1) begin
                model_accept(d, 1'b0);
                hit = (cnt_m == 23'd3) && (ph_m == 1);
                d++;
            end
            @(negedge clk);
            rec_audio_data = d;
            if (hit) begin
                hit = 0;
                checks++;
                if (w_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL max_ready got %b expected 0", w_ready);
                end
            end
            n++;
        end
        rec_audio_valid = 1'b0;
        wait_done(d0, "max");
        use_max = 0;
        max_m = 23'h7FFFF0;
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [31:0] d = 32'h900;
        do_reset();
        ack_lat = 1;
        hold = 1;
        start_rec(23'h020);
        while (cnt_m < 23'd2) begin
            send(d, 1'b0);
            d++;
        end
        rec_audio_valid = 1'b0;
        i_rst = 1'b1;
        @(negedge clk);
        sb.delete();
        d0 = done_cnt;
        check_idle_outputs("midrst");
        i_rst = 1'b0;
        hold = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt != d0 || w_write !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet got done=%0d write=%b expected 0 0",
                     done_cnt - d0, w_write);
        end
        start_rec(23'h030);
        send(32'hC1, 1'b0);
        send(32'hC2, 1'b0);
        send(32'hC3, 1'b0);
        rec_audio_valid = 1'b0;
        stop_rec();
        wait_done(d0, "midrst_restart");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_pause();
        test_immediate_stop();
        test_max();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/record_core.md
# record_core

Audio capture engine: the write-direction counterpart of the playback path. Once started, it accepts 32-bit samples from the audio codec interface and keeps every DECIM-th one. It buffers kept samples in a small FIFO and writes them to SDRAM starting at `rec_select + 1`. On stop it drains the FIFO, then writes the stored-word count as a header word at `rec_select`. The top-level controller starts it and reads back the layout with the playback core.

## Interface

Parameters:
- `FIFO_DEPTH`, 4 — sample buffer entries (power of two, ≥2)
- `DECIM`, 2 — keep one of every DECIM accepted samples (first of each group)
- `MAX_WORDS`, 23'h7FFFF0 — stored-word limit; reaching it forces stop

Ports:
- `i_clk` in 1 — clock; all state changes on rising edge
- `i_rst` in 1 — synchronous, active-high reset
- `rec_start` in 1 — begin recording (sampled in IDLE only)
- `rec_select` in 23 — header address; latched on start
- `rec_pause` in 1 — level; while high, accepted samples are discarded
- `rec_stop` in 1 — end recording
- `rec_done` out 1 — one-cycle pulse when header write completes
- `rec_write` out 1 — SDRAM write request
- `rec_addr` out 23 — SDRAM word address
- `rec_writedata` out 32 — SDRAM write data
- `rec_sdram_finished` in 1 — one-cycle acknowledge; write committed
- `rec_audio_valid` in 1 — codec sample valid
- `rec_audio_data` in 32 — codec sample
- `rec_audio_ready` out 1 — core accepts sample this cycle

## Operation

- States: IDLE, RECORD, FLUSH, WRITE_LEN.
- IDLE:
  - `rec_audio_ready`=0, `rec_write`=0.
  - On `rec_start`, latch `sel`=`rec_select`, set write pointer `wptr`=`rec_select+1`, `count`=0, decimation phase=0, clear FIFO, go to RECORD.
- RECORD:
  - `rec_audio_ready` = !fifo_full. Accept = valid && ready.
  - On accept with `rec_pause`=0: if phase==0, push sample and increment `count`. Then phase = (phase+1) mod DECIM.
  - On accept with `rec_pause`=1: sample dropped, phase forced to 0.
  - Go to FLUSH when any of these holds:
    - `rec_stop`=1; a sample accepted in the same cycle is still processed.
    - `count` reaches MAX_WORDS; the push that reaches it is kept, and further samples are not accepted.
  - `rec_stop` has priority over `rec_pause`. `rec_start` is ignored outside IDLE.
- SDRAM drain (RECORD and FLUSH):
  - `rec_write`=1 whenever the FIFO is non-empty.
  - `rec_addr`=`wptr`; `rec_writedata`=FIFO head. Both stay stable until `rec_sdram_finished`.
  - On finished: pop, `wptr`=`wptr`+1 (mod 2^23).
- FLUSH:
  - `rec_audio_ready`=0. Continue draining.
  - When the FIFO is empty and no write is outstanding, go to WRITE_LEN.
- WRITE_LEN:
  - `rec_write`=1, `rec_addr`=`sel`, `rec_writedata`={9'b0,`count`}.
  - On finished: `rec_done`=1 in that same cycle, go to IDLE.
- `count` is 23 bits and equals the number of data words written.
- FIFO:
  - Push and pop in the same cycle are legal when not full.
  - No push when full, because ready is low.
  - Occupancy never exceeds FIFO_DEPTH; no overflow or underflow is possible.
- Reset mid-operation: return to IDLE, FIFO emptied, no header written, no `rec_done`.

## Timing

- Reset values: `rec_done`=0, `rec_write`=0, `rec_audio_ready`=0, `rec_addr`=0, `rec_writedata`=0; state IDLE, `count`=0.
- `rec_start` at cycle N: state RECORD and `rec_audio_ready`=1 at N+1.
- Sample pushed at cycle N: `rec_write`=1 with that data at N+1 at the earliest.
- SDRAM write handshake:
  - `rec_sdram_finished` at cycle M pops the word.
  - The next word, if present, is presented at M+1 with `rec_write` still high.
  - A word with no finished acknowledge is held indefinitely.
- Stop latency:
  - `rec_stop` at N: `rec_audio_ready`=0 from N+1.
  - Header write begins the cycle after the last data finished, or at N+1 if the FIFO is already empty.
- `rec_done` is combinational: high only in the WRITE_LEN cycle where `rec_sdram_finished`=1.
- Outputs other than `rec_done` depend only on registered state.

## Test plan

- Basic capture, DECIM=2:
  - Stimulus: `rec_select`=0x100, 8 back-to-back samples 0xA0..0xA7, finished one cycle after each write, then stop.
  - Required: data writes 0xA0@0x101, 0xA2@0x102, 0xA4@0x103, 0xA6@0x104; then header 4@0x100; `rec_done` pulses once.
- Backpressure:
  - Stimulus: SDRAM finished withheld for 20 cycles, codec valid constant.
  - Required: exactly FIFO_DEPTH words buffered, then `rec_audio_ready`=0; after release, writes resume in order with no loss or duplicate.
- Pause:
  - Stimulus: samples 1..10, `rec_pause` high during samples 3..6.
  - Required: stored 1, 7, 9; header count=3.
- Immediate stop:
  - Stimulus: start followed by stop the next cycle, no samples.
  - Required: single write of 0 @`rec_select`, then `rec_done`.
- MAX_WORDS:
  - Stimulus: build with MAX_WORDS=3, continuous samples, no stop.
  - Required: 3 data words, automatic header 3, `rec_done`; ready low after the third kept sample.
- Reset mid-operation:
  - Stimulus: `i_rst` asserted while 2 words are buffered.
  - Required: next cycle all outputs at reset values; no header write; a new start works normally.
